// File: rtl/led_7seg_scan.sv
// Time-multiplexed driver for common-anode 7-segment digits on a shared bus.
// Scans one digit per REFRESH_DIV cycles, holds anodes off for BLANK_CYC
// cycles at the start of each slot, and commits new data only at frame end.
module led_7seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      lz_en,
  input  logic                      blank_in,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic                      tick;
  logic                      frame_end;
  logic [4*NUM_DIGITS-1:0]   shadow_data;
  logic [NUM_DIGITS-1:0]     shadow_dp;
  logic [4*NUM_DIGITS-1:0]   active_data;
  logic [NUM_DIGITS-1:0]     active_dp;
  logic                      pending;
  logic [NUM_DIGITS-1:0]     suppress;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic                      cur_sup;
  logic                      digit_on;
  logic                      zero_run;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  assign tick      = (cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);
  assign digit_on  = (cnt >= CNT_ON) && !blank_in;

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Shadow capture and frame-end commit; commit uses the pre-load shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      active_data <= '0;
      active_dp   <= '0;
      pending     <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        active_data <= shadow_data;
        active_dp   <= shadow_dp;
        pending     <= 1'b0;
      end
      if (load) begin
        shadow_data <= data_in;
        shadow_dp   <= dp_in;
        pending     <= 1'b1;
      end
    end
  end

  // Leading-zero mask: scan from the top digit down while nibbles and dps are clear.
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run
               && (active_data[4*(NUM_DIGITS-1-k) +: 4] == 4'h0)
               && !active_dp[NUM_DIGITS-1-k];
      suppress[NUM_DIGITS-1-k] = lz_en && zero_run && (k != NUM_DIGITS - 1);
    end
  end

  // Select the nibble, dp and suppression bit of the digit being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) == idx) begin
        cur_nib = active_data[4*i +: 4];
        cur_dp  = active_dp[i];
        cur_sup = suppress[i];
      end
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (digit_on) begin
        an <= ~(NUM_DIGITS'(1) << idx);
        if (cur_sup) begin
          seg <= 7'h7F;
          dp  <= 1'b1;
        end else begin
          seg <= glyph(cur_nib);
          dp  <= ~cur_dp;
        end
      end else begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_7seg_scan.sv
// Randomized self-checking bench for led_7seg_scan with a cycle-count based model.
module tb_led_7seg_scan;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  data_in = '0;
  logic [3:0]   dp_in = '0;
  logic         load = 1'b0;
  logic         lz_en = 1'b0;
  logic         blank_in = 1'b0;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;
  logic         frame_done;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  led_7seg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .load(load),
    .lz_en(lz_en), .blank_in(blank_in), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: position in the scan follows from cycles elapsed since reset.
  int          c;
  int          mcnt, midx, lead;
  logic        fe;
  logic [15:0] m_sh, m_act;
  logic [3:0]  m_shdp, m_actdp;
  logic        m_pend;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic [3:0]  e_an = 4'hF;
  logic        e_fd = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = 0; m_sh = '0; m_shdp = '0; m_act = '0; m_actdp = '0; m_pend = 1'b0;
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
    end else begin
      mcnt = c % RD;
      midx = (c / RD) % ND;
      fe   = (mcnt == RD - 1) && (midx == ND - 1);
      e_fd = fe;
      lead = 0;
      for (int i = 0; i < ND; i++)
        if (m_act[i*4 +: 4] != 4'h0 || m_actdp[i]) lead = i;
      if (mcnt >= BC && !blank_in) begin
        e_an = 4'hF & ~(4'b0001 << midx);
        if (lz_en && midx > lead) begin
          e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_seg = GLYPH[m_act[midx*4 +: 4]];
          e_dp  = ~m_actdp[midx];
        end
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      if (fe && m_pend) begin
        m_act = m_sh; m_actdp = m_shdp; m_pend = 1'b0;
      end
      if (load) begin
        m_sh = data_in; m_shdp = dp_in; m_pend = 1'b1;
      end
      c++;
    end
  end

  // Compare every cycle against the model, plus a one-anode-at-most check.
  always @(negedge clk) begin
    checks++;
    if ({seg, dp, an, frame_done} !== {e_seg, e_dp, e_an, e_fd}) begin
      errors++;
      $display("FAIL model_cmp t=%0t got seg=%h dp=%b an=%h fd=%b want seg=%h dp=%b an=%h fd=%b",
               $time, seg, dp, an, frame_done, e_seg, e_dp, e_an, e_fd);
    end
    checks++;
    if ($countones(~an) > 1) begin
      errors++;
      $display("FAIL an_onehot t=%0t got an=%h want at most one low bit", $time, an);
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic wait_an(input logic [3:0] v, input int lim);
    int n = 0;
    while (an !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (an !== v) begin
      errors++;
      $display("FAIL wait_an_timeout t=%0t got an=%h want %h", $time, an, v);
    end
  endtask

  task automatic wait_fd(input int lim);
    int n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_fd_timeout t=%0t got fd=%b want 1", $time, frame_done);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    data_in = d; dp_in = p; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic show(input logic [15:0] d, input logic [3:0] p);
    do_load(d, p);
    wait_fd(80);
    wait_fd(80);
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++)
      r[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    return r;
  endfunction

  initial begin
    // Reset held with toggling inputs.
    repeat (5) begin
      @(negedge clk);
      data_in = 16'($urandom); dp_in = 4'($urandom); load = 1'($urandom);
    end
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an", {4'h0, an}, 8'h0F);
    load = 1'b0; data_in = '0; dp_in = '0;
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rel_an_2", {4'h0, an}, 8'h0F);
    @(negedge clk);
    chk("rel_an_3", {4'h0, an}, 8'h0E);

    // Scan of 0x1234.
    show(16'h1234, 4'h0);
    wait_an(4'hE, 40); chk("scan_d0", {1'b0, seg}, 8'h19);
    wait_an(4'hD, 40); chk("scan_d1", {1'b0, seg}, 8'h30);
    wait_an(4'hB, 40); chk("scan_d2", {1'b0, seg}, 8'h24);
    wait_an(4'h7, 40); chk("scan_d3", {1'b0, seg}, 8'h79);

    // Mid-frame load stays hidden until the frame end.
    wait_fd(80);
    repeat (10) @(negedge clk);
    do_load(16'hABCD, 4'h0);
    wait_an(4'h7, 40); chk("atomic_old", {1'b0, seg}, 8'h79);
    wait_fd(80);
    wait_an(4'hE, 40); chk("atomic_d0", {1'b0, seg}, 8'h21);
    wait_an(4'hD, 40); chk("atomic_d1", {1'b0, seg}, 8'h46);
    wait_an(4'hB, 40); chk("atomic_d2", {1'b0, seg}, 8'h03);
    wait_an(4'h7, 40); chk("atomic_d3", {1'b0, seg}, 8'h08);

    // Load coincident with the frame-end tick commits one frame later.
    wait_fd(80);
    repeat (31) @(negedge clk);
    do_load(16'h5678, 4'h0);
    chk("coinc_fd", {7'h0, frame_done}, 8'h01);
    wait_an(4'hE, 40); chk("coinc_old", {1'b0, seg}, 8'h21);
    wait_fd(80);
    wait_an(4'hE, 40); chk("coinc_new", {1'b0, seg}, 8'h00);

    // Leading-zero suppression.
    lz_en = 1'b1;
    show(16'h0050, 4'h0);
    wait_an(4'hE, 40); chk("lz_d0", {1'b0, seg}, 8'h40);
    wait_an(4'hD, 40); chk("lz_d1", {1'b0, seg}, 8'h12);
    wait_an(4'hB, 40); chk("lz_d2", {1'b0, seg}, 8'h7F);
    wait_an(4'h7, 40); chk("lz_d3", {1'b0, seg}, 8'h7F);
    show(16'h0000, 4'h0);
    wait_an(4'hE, 40); chk("lz0_d0", {1'b0, seg}, 8'h40);
    wait_an(4'hD, 40); chk("lz0_d1", {1'b0, seg}, 8'h7F);
    show(16'h0050, 4'b0100);
    wait_an(4'hB, 40); chk("lzdp_seg", {1'b0, seg}, 8'h40);
    chk("lzdp_dp", {7'h0, dp}, 8'h00);
    wait_an(4'h7, 40); chk("lzdp_d3", {1'b0, seg}, 8'h7F);

    // Global blanking.
    blank_in = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("blank_an", {4'h0, an}, 8'h0F);
    repeat (18) @(negedge clk);
    blank_in = 1'b0;

    // Randomized traffic.
    repeat (800) begin
      @(negedge clk);
      load     = ($urandom_range(0, 15) == 0);
      data_in  = rand_data();
      dp_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      blank_in = ($urandom_range(0, 31) == 0) ? ~blank_in : blank_in;
    end
    load = 1'b0; blank_in = 1'b0;

    // Reset mid-frame acts immediately.
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_an", {4'h0, an}, 8'h0F);
    chk("mid_rst_dpfd", {6'h0, dp, frame_done}, 8'h02);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) begin
      @(negedge clk);
      load    = ($urandom_range(0, 7) == 0);
      data_in = rand_data();
      dp_in   = 4'($urandom);
    end
    load = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
